// File: rtl/scrambler_seq_ctrl_pkg.sv
// Shared constants, state encoding and header helper for the 64b/66b TX scrambler sequencer.
package scrambler_seq_ctrl_pkg;

  localparam logic [1:0]  SyncData = 2'b01;
  localparam logic [1:0]  SyncCtrl = 2'b10;

  localparam logic [63:0] IdleBlk  = 64'h0000_0000_0000_001E;
  // Error block: type byte 0x1E in the LSBs, eight 7-bit /E/ characters above it.
  localparam logic [63:0] ErrBlk   = {{8{7'h1E}}, 8'h1E};

  typedef enum logic [1:0] {
    StInit  = 2'b00,
    StPrime = 2'b01,
    StRun   = 2'b10
  } state_e;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SyncData) || (hdr == SyncCtrl);
  endfunction

endpackage

// File: rtl/scrambler_seq_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module scrambler_seq_ctrl_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/scrambler_seq_ctrl.sv
// Sequences the 64b/66b TX scrambler: reset hold, idle priming, then one block per cycle with
// idle insertion and invalid-header replacement; registers scrambled output with its header.
module scrambler_seq_ctrl
  import scrambler_seq_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES  = 4,
  parameter int unsigned PRIME_BLOCKS = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_hdr,
  input  logic [63:0]      in_data,
  output logic             scr_reset,
  output logic [63:0]      scr_din,
  input  logic [63:0]      scr_dout,
  output logic             out_valid,
  output logic [1:0]       out_hdr,
  output logic [63:0]      out_data,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] idle_cnt,
  output logic [CNT_W-1:0] hdr_err_cnt,
  output logic [1:0]       state
);

  localparam int unsigned CycMax = (INIT_CYCLES > PRIME_BLOCKS) ? INIT_CYCLES : PRIME_BLOCKS;
  localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;

  localparam logic [CycW-1:0] InitLast  = CycW'(INIT_CYCLES - 1);
  localparam logic [CycW-1:0] PrimeLast = (PRIME_BLOCKS > 0) ? CycW'(PRIME_BLOCKS - 1) : '0;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [1:0]      sel_hdr;
  logic            inc_blk, inc_idle, inc_err;

  logic            out_valid_q;
  logic [1:0]      out_hdr_q;
  logic [63:0]     out_data_q;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    scr_reset = 1'b0;
    in_ready  = 1'b0;
    scr_din   = IdleBlk;
    sel_hdr   = SyncCtrl;
    inc_blk   = 1'b0;
    inc_idle  = 1'b0;
    inc_err   = 1'b0;

    unique case (state_q)
      StInit: begin
        scr_reset = 1'b1;
        if (cyc_q == InitLast) begin
          cyc_d   = '0;
          state_d = (PRIME_BLOCKS == 0) ? StRun : StPrime;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StPrime: begin
        if (cyc_q == PrimeLast) begin
          cyc_d   = '0;
          state_d = StRun;
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StRun: begin
        in_ready = en;
        // The scrambler never stalls: anything not accepted becomes an idle block.
        if (en) begin
          inc_blk = 1'b1;
          if (in_valid) begin
            if (hdr_is_valid(in_hdr)) begin
              scr_din = in_data;
              sel_hdr = in_hdr;
            end else begin
              scr_din = ErrBlk;
              inc_err = 1'b1;
            end
          end else begin
            inc_idle = 1'b1;
          end
        end
      end
      default: begin
        state_d = StInit;
        cyc_d   = '0;
      end
    endcase

    if (!en) begin
      state_d = StInit;
      cyc_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_hdr_q   <= 2'b00;
      out_data_q  <= '0;
    end else if (state_q == StInit) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b1;
      out_hdr_q   <= sel_hdr;
      out_data_q  <= scr_dout;
    end
  end

  scrambler_seq_ctrl_sat_counter #(.CNT_W(CNT_W)) u_blk_cnt (
    .CLK     (CLK),
    .reset_n (reset_n),
    .inc     (inc_blk),
    .count   (blk_cnt)
  );

  scrambler_seq_ctrl_sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
    .CLK     (CLK),
    .reset_n (reset_n),
    .inc     (inc_idle),
    .count   (idle_cnt)
  );

  scrambler_seq_ctrl_sat_counter #(.CNT_W(CNT_W)) u_hdr_err_cnt (
    .CLK     (CLK),
    .reset_n (reset_n),
    .inc     (inc_err),
    .count   (hdr_err_cnt)
  );

  assign out_valid = out_valid_q;
  assign out_hdr   = out_hdr_q;
  assign out_data  = out_data_q;
  assign state     = state_q;

endmodule

// File: tb/tb_scrambler_seq_ctrl.sv
// Self-checking bench: behavioural x^58+x^39+1 scrambler on the scr_* loop, schedule-based model.
module tb_scrambler_seq_ctrl;

  localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_hdr;
  logic [63:0] in_data;
  logic        scr_reset;
  logic [63:0] scr_din;
  logic [63:0] scr_dout;
  logic        out_valid;
  logic [1:0]  out_hdr;
  logic [63:0] out_data;
  logic [31:0] blk_cnt, idle_cnt, hdr_err_cnt;
  logic [1:0]  state;

  // Second instance: CNT_W=4, single INIT cycle, PRIME skipped, source always idle.
  logic        in_ready4, scr_reset4, out_valid4;
  logic [63:0] scr_din4, out_data4;
  logic [1:0]  out_hdr4, state4;
  logic [3:0]  blk_cnt4, idle_cnt4, hdr_err_cnt4;

  always #5 CLK = ~CLK;

  scrambler_seq_ctrl dut (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_hdr      (in_hdr),
    .in_data     (in_data),
    .scr_reset   (scr_reset),
    .scr_din     (scr_din),
    .scr_dout    (scr_dout),
    .out_valid   (out_valid),
    .out_hdr     (out_hdr),
    .out_data    (out_data),
    .blk_cnt     (blk_cnt),
    .idle_cnt    (idle_cnt),
    .hdr_err_cnt (hdr_err_cnt),
    .state       (state)
  );

  scrambler_seq_ctrl #(.INIT_CYCLES(1), .PRIME_BLOCKS(0), .CNT_W(4)) dut4 (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .en          (1'b1),
    .in_valid    (1'b0),
    .in_ready    (in_ready4),
    .in_hdr      (2'b00),
    .in_data     (64'h0),
    .scr_reset   (scr_reset4),
    .scr_din     (scr_din4),
    .scr_dout    (scr_din4),
    .out_valid   (out_valid4),
    .out_hdr     (out_hdr4),
    .out_data    (out_data4),
    .blk_cnt     (blk_cnt4),
    .idle_cnt    (idle_cnt4),
    .hdr_err_cnt (hdr_err_cnt4),
    .state       (state4)
  );

  // Self-synchronous scrambler, LSB first: out = in ^ s[38] ^ s[57]; returns {dout, next_state}.
  function automatic logic [121:0] scramble(input logic [57:0] s, input logic [63:0] din);
    logic [57:0] st;
    logic [63:0] o;
    st = s;
    for (int i = 0; i < 64; i++) begin
      o[i] = din[i] ^ st[38] ^ st[57];
      st   = {st[56:0], o[i]};
    end
    return {o, st};
  endfunction

  logic [57:0]  scr_st;
  logic [57:0]  scr_nx;
  logic [121:0] scr_res;
  assign scr_res  = scramble(scr_st, scr_din);
  assign scr_dout = scr_res[121:58];
  assign scr_nx   = scr_res[57:0];

  always @(posedge CLK) begin
    if (scr_reset) scr_st <= '0;
    else           scr_st <= scr_nx;
  end

  int          checks = 0;
  int          errors = 0;
  logic [63:0] err_blk;

  // Reference model state.
  int          since;
  logic [57:0] ref_st;
  logic        exp_ov;
  logic [1:0]  exp_oh;
  logic [63:0] exp_od;
  logic [31:0] exp_blk, exp_idle, exp_err;
  logic [63:0] cap_din;
  logic        cap_ready;
  logic [1:0]  cap_hdr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance, check registered outputs.
  task automatic run_cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                           input logic e);
    int           ph;
    logic         rdy, acc, good;
    logic [63:0]  din;
    logic [1:0]   hd;
    logic [121:0] r;
    en = e; in_valid = v; in_hdr = h; in_data = d;
    #1;
    ph   = (since < 4) ? 0 : (since < 20) ? 1 : 2;
    rdy  = (ph == 2) && e;
    acc  = v && rdy;
    good = (h == 2'b01) || (h == 2'b10);
    din  = (acc && good) ? d : (acc ? err_blk : IDLE);
    hd   = (acc && good) ? h : 2'b10;
    chk("state", 64'(state), 64'(ph));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("scr_reset", 64'(scr_reset), 64'(ph == 0));
    chk("scr_din", scr_din, din);
    cap_din   = scr_din;
    cap_ready = in_ready;
    if (ph == 0) begin
      ref_st = '0;
      exp_ov = 1'b0;
    end else begin
      r      = scramble(ref_st, din);
      exp_od = r[121:58];
      ref_st = r[57:0];
      exp_ov = 1'b1;
      exp_oh = hd;
    end
    if (ph == 2 && e) begin
      exp_blk++;
      if (!v) exp_idle++;
      else if (!good) exp_err++;
    end
    since = e ? since + 1 : 0;
    @(posedge CLK);
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("out_hdr", 64'(out_hdr), 64'(exp_oh));
    chk("out_data", out_data, exp_od);
    chk("blk_cnt", 64'(blk_cnt), 64'(exp_blk));
    chk("idle_cnt", 64'(idle_cnt), 64'(exp_idle));
    chk("hdr_err_cnt", 64'(hdr_err_cnt), 64'(exp_err));
    cap_hdr = out_hdr;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 64'(state), 64'd0);
    chk({tag, "_scr_reset"}, 64'(scr_reset), 64'd1);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_hdr"}, 64'(out_hdr), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
    chk({tag, "_idle_cnt"}, 64'(idle_cnt), 64'd0);
    chk({tag, "_hdr_err_cnt"}, 64'(hdr_err_cnt), 64'd0);
    chk({tag, "_idle_cnt4"}, 64'(idle_cnt4), 64'd0);
    since = 0; ref_st = '0; exp_ov = 1'b0; exp_oh = 2'b00; exp_od = '0;
    exp_blk = '0; exp_idle = '0; exp_err = '0;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  h;
    logic [63:0] d;
    logic [63:0] exp_din;
    logic [1:0]  exp_hdr;
  } vec_t;

  vec_t        tbl[7];
  logic [31:0] s_blk, s_idle, s_err;

  initial begin
    err_blk = 64'h1E;
    for (int i = 0; i < 8; i++) err_blk = err_blk | (64'h1E << (8 + 7 * i));

    tbl[0] = '{1'b1, 2'b01, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'b01};
    tbl[1] = '{1'b0, 2'b01, 64'h1111_2222_3333_4444, IDLE, 2'b10};
    tbl[2] = '{1'b0, 2'b00, 64'h5555_6666_7777_8888, IDLE, 2'b10};
    tbl[3] = '{1'b0, 2'b10, 64'h9999_AAAA_BBBB_CCCC, IDLE, 2'b10};
    tbl[4] = '{1'b1, 2'b00, 64'hAAAA_AAAA_AAAA_AAAA, err_blk, 2'b10};
    tbl[5] = '{1'b1, 2'b11, 64'h5555_5555_5555_5555, err_blk, 2'b10};
    tbl[6] = '{1'b1, 2'b10, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 2'b10};

    reset_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_hdr = 2'b00; in_data = '0;
    #3;
    reset_checks("por");
    #4 reset_n = 1'b1;

    // Bring-up: 4 INIT cycles then 16 primed idles.
    run_cycle(1'b0, 2'b00, 64'h0, 1'b1);
    chk("dut4_prime_skip", 64'(state4), 64'd2);
    for (int i = 1; i < 20; i++) run_cycle(1'b0, 2'b00, 64'h0, 1'b1);
    chk("run_after_20", 64'(state), 64'd2);

    s_blk = blk_cnt; s_idle = idle_cnt; s_err = hdr_err_cnt;
    for (int i = 0; i < 7; i++) begin
      run_cycle(tbl[i].v, tbl[i].h, tbl[i].d, 1'b1);
      chk("tbl_scr_din", cap_din, tbl[i].exp_din);
      chk("tbl_out_hdr", 64'(cap_hdr), 64'(tbl[i].exp_hdr));
    end
    chk("tbl_blk_delta", 64'(blk_cnt - s_blk), 64'd7);
    chk("tbl_idle_delta", 64'(idle_cnt - s_idle), 64'd3);
    chk("tbl_err_delta", 64'(hdr_err_cnt - s_err), 64'd2);

    chk("sat_idle_cnt4", 64'(idle_cnt4), 64'd15);
    chk("sat_blk_cnt4", 64'(blk_cnt4), 64'd15);
    chk("sat_err_cnt4", 64'(hdr_err_cnt4), 64'd0);

    // Enable drop mid-stream with a valid block offered.
    s_blk = blk_cnt; s_idle = idle_cnt; s_err = hdr_err_cnt;
    run_cycle(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0001, 1'b0);
    chk("endrop_in_ready", 64'(cap_ready), 64'd0);
    run_cycle(1'b1, 2'b01, 64'hDEAD_BEEF_0000_0002, 1'b1);
    chk("endrop_out_valid", 64'(out_valid), 64'd0);
    chk("endrop_blk_kept", 64'(blk_cnt), 64'(s_blk));
    chk("endrop_idle_kept", 64'(idle_cnt), 64'(s_idle));
    chk("endrop_err_kept", 64'(hdr_err_cnt), 64'(s_err));
    for (int i = 0; i < 22; i++) run_cycle(1'b0, 2'b00, 64'h0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), 2'($urandom), {$urandom, $urandom},
                ($urandom_range(0, 39) != 0));
    end
    for (int i = 0; i < 25; i++) run_cycle(1'b1, 2'b01, {$urandom, $urandom}, 1'b1);

    // Asynchronous reset away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    reset_checks("async");
    #3 reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      run_cycle(($urandom_range(0, 1) != 0), 2'($urandom), {$urandom, $urandom}, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
